// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer for a 16-bit load/store/ALU datapath
// Moore FSM with PC and IR; every output decodes from state_q and ir_q only.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] InstrData,
    output logic [6:0]  PC_Addr,
    output logic [7:0]  D_Addr,
    output logic        D_Wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic        Halted,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    state_t      state_q, state_d;
    logic [6:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            pc_q    <= 7'd0;
            ir_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = InstrData;
                pc_d    = pc_q + 7'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Register-file address fields sit at the ADD/SUB positions unless a state overrides them.
    always_comb begin
        D_Addr     = ir_q[11:4];
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = ir_q[3:0];
        RF_W_en    = 1'b0;
        RF_Ra_addr = ir_q[11:8];
        RF_Rb_addr = ir_q[7:4];
        ALU_s0     = ALU_PASS;
        case (state_q)
            S_STORE: begin
                D_Wr       = 1'b1;
                RF_Ra_addr = ir_q[3:0];
            end
            S_LOAD_B: begin
                RF_s    = 1'b1;
                RF_W_en = 1'b1;
            end
            S_ADD: begin
                RF_W_en = 1'b1;
                ALU_s0  = ALU_ADD;
            end
            S_SUB: begin
                RF_W_en = 1'b1;
                ALU_s0  = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign PC_Addr = pc_q;
    assign Halted  = (state_q == S_HALT);
    assign State   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] InstrData;
    logic [6:0]  PC_Addr;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic        Halted;
    logic [3:0]  State;

    logic [15:0] imem [0:127];

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .InstrData  (InstrData),
        .PC_Addr    (PC_Addr),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted),
        .State      (State)
    );

    assign InstrData = imem[PC_Addr];

    always #5 clk = ~clk;

    // {is_rf_write, D_Addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0, RF_s, State}
    logic [28:0] wr_q [$];
    int          pc_exp_q [$];
    int          len_q [$];

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int cyc = 0;
    int last_fetch = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic is_rf, input logic [7:0] da, input logic [3:0] w,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu,
                           input logic rfs, input logic [3:0] st);
        wr_q.push_back({is_rf, da, w, ra, rb, alu, rfs, st});
    endtask

    // Monitor: pops write events and fetch records as the DUT produces them.
    always @(negedge clk) begin
        cyc++;
        if (RF_W_en || D_Wr) writes_seen++;
        if (!reset) begin
            chk("write_exclusive", {31'd0, RF_W_en & D_Wr}, 32'd0);
            if (RF_W_en || D_Wr) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: state %0d RF_W_en %0b D_Wr %0b", State, RF_W_en, D_Wr);
                end else begin
                    chk("write_fields",
                        {3'd0, RF_W_en, D_Addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0, RF_s, State},
                        {3'd0, wr_q.pop_front()});
                end
            end
            if (State == 4'd1) begin
                if (pc_exp_q.size() > 0) chk("fetch_pc", {25'd0, PC_Addr}, pc_exp_q.pop_front());
                if (last_fetch >= 0 && len_q.size() > 0) chk("instr_cycles", cyc - last_fetch, len_q.pop_front());
                last_fetch = cyc;
            end
        end else begin
            last_fetch = -1;
        end
    end

    task automatic wait_halt(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (Halted) begin
                seen = 1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int seen_before;
        bit found;

        reset = 1'b1;
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        imem[0] = 16'h21A3;
        imem[1] = 16'h3452;
        imem[2] = 16'h1FF7;
        imem[3] = 16'h4123;
        imem[4] = 16'h0000;
        imem[5] = 16'h7ABC;
        imem[6] = 16'h5000;
        repeat (2) @(negedge clk);

        chk("reset_state", {28'd0, State}, 32'd0);
        chk("reset_pc", {25'd0, PC_Addr}, 32'd0);
        chk("reset_enables", {28'd0, RF_W_en, D_Wr, RF_s, Halted}, 32'd0);
        chk("reset_alu", {29'd0, ALU_s0}, 32'd0);

        push_wr(1'b1, 8'h1A, 4'h3, 4'h1, 4'hA, 3'b000, 1'b1, 4'd5);
        push_wr(1'b1, 8'h45, 4'h2, 4'h4, 4'h5, 3'b001, 1'b0, 4'd7);
        push_wr(1'b0, 8'hFF, 4'h7, 4'h7, 4'hF, 3'b000, 1'b0, 4'd6);
        push_wr(1'b1, 8'h12, 4'h3, 4'h1, 4'h2, 3'b010, 1'b0, 4'd8);
        for (int i = 0; i < 7; i++) pc_exp_q.push_back(i);
        len_q.push_back(4);
        for (int i = 0; i < 5; i++) len_q.push_back(3);

        reset = 1'b0;
        @(negedge clk);
        chk("first_fetch_state", {28'd0, State}, 32'd1);
        chk("first_fetch_pc", {25'd0, PC_Addr}, 32'd0);

        wait_halt("program_halts", 100);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("fetch_queue_drained", pc_exp_q.size(), 0);
        chk("len_queue_drained", len_q.size(), 0);

        for (int i = 0; i < 20; i++) begin
            chk("halt_state", {27'd0, Halted, State}, {27'd0, 1'b1, 4'd9});
            chk("halt_pc_frozen", {25'd0, PC_Addr}, 32'd7);
            chk("halt_no_writes", {30'd0, RF_W_en, D_Wr}, 32'd0);
            @(negedge clk);
        end

        // PC wrap: 128 NOOPs then back to address 0.
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 128; i++) pc_exp_q.push_back(i);
        pc_exp_q.push_back(0);
        for (int i = 0; i < 128; i++) len_q.push_back(3);
        reset = 1'b0;
        for (int i = 0; i < 500 && pc_exp_q.size() > 0; i++) @(negedge clk);
        chk("wrap_fetch_drained", pc_exp_q.size(), 0);
        chk("wrap_len_drained", len_q.size(), 0);

        // Reset while sitting in LOAD_A must abort without a register write.
        reset = 1'b1;
        @(negedge clk);
        imem[0] = 16'h21A3;
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (State == 4'd4) begin
                found = 1;
                break;
            end
        end
        chk("reached_load_a", {31'd0, found}, 32'd1);
        seen_before = writes_seen;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_state", {28'd0, State}, 32'd0);
        chk("async_reset_pc", {25'd0, PC_Addr}, 32'd0);
        chk("async_reset_wen", {31'd0, RF_W_en}, 32'd0);
        imem[0] = 16'h5000;
        repeat (3) @(negedge clk);
        chk("aborted_load_no_write", writes_seen, seen_before);
        reset = 1'b0;
        wait_halt("halt_after_abort", 20);
        chk("no_write_after_abort", writes_seen, seen_before);
        chk("final_wr_queue_empty", wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk in 1, positive-edge system clock.
REQ-002 SHALL have ports: reset in 1, asynchronous active-high reset that clears all state.
REQ-003 SHALL have ports: InstrData in 16, instruction word read combinationally from instruction memory at PC_Addr.
REQ-004 SHALL have ports: PC_Addr out 7, program counter driving instruction memory.
REQ-005 SHALL have ports: D_Addr out 8, data memory address; D_Wr out 1, data memory write enable.
REQ-006 SHALL have ports: RF_s out 1, register-file write-data mux select: 1 = data memory, 0 = ALU.
REQ-007 SHALL have ports: RF_W_addr out 4 and RF_W_en out 1, register-file write port controls.
REQ-008 SHALL have ports: RF_Ra_addr out 4 and RF_Rb_addr out 4, register-file read addresses.
REQ-009 SHALL have ports: ALU_s0 out 3, ALU operation select: 000 pass-A, 001 add, 010 subtract.
REQ-010 SHALL have ports: Halted out 1, high while in HALT; State out 4, current state encoding for debug.

Function
REQ-011 SHALL hold internal registers PC[6:0], IR[15:0] and a Moore FSM, all updated on posedge clk.
REQ-012 SHALL decode opcode IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; 0110-1111 execute as NOOP.
REQ-013 SHALL use field layouts: LOAD/STORE addr = IR[11:4], reg = IR[3:0]; ADD/SUB Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0].
REQ-014 SHALL use states/encodings: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
REQ-015 SHALL transition INIT -> FETCH unconditionally.
REQ-016 SHALL, in FETCH, load IR <= InstrData and PC <= PC+1, then go to DECODE.
REQ-017 SHALL, in DECODE, go to the opcode's execute state (LOAD -> LOAD_A).
REQ-018 SHALL transition LOAD_A -> LOAD_B; LOAD_B, STORE, ADD, SUB and NOOP -> FETCH.
REQ-019 SHALL keep HALT absorbing until reset.
REQ-020 SHALL wrap PC modulo 128: fetch at 127 sets PC to 0; no flag is raised.
REQ-021 SHALL drive D_Addr = IR[11:4] in every state.
REQ-022 SHALL drive D_Wr = 1 only in STORE, with RF_Ra_addr = IR[3:0].
REQ-023 SHALL, in LOAD_A, drive D_Addr only; in LOAD_B, drive RF_s = 1, RF_W_en = 1, RF_W_addr = IR[3:0].
REQ-024 SHALL, in ADD/SUB, drive RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], RF_W_en = 1, RF_s = 0, ALU_s0 = 001/010.
REQ-025 SHALL otherwise drive RF_W_en = 0, D_Wr = 0, RF_s = 0, ALU_s0 = 000, and RF_W_addr/RF_Ra_addr/RF_Rb_addr from the ADD/SUB field positions.
REQ-026 SHALL assert at most one of RF_W_en and D_Wr in any cycle.
REQ-027 SHALL complete instructions in these cycle counts, fetch to fetch: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles.
REQ-028 SHALL generate all outputs as Moore decodes of the state and IR, glitch-free relative to clk.

Reset
REQ-029 SHALL, on reset assertion, immediately and asynchronously set State = INIT, PC = 0 and IR = 0.
REQ-030 SHALL force RF_W_en = 0, D_Wr = 0, RF_s = 0, ALU_s0 = 000 and Halted = 0 during reset.
REQ-031 SHALL abort any in-flight instruction on reset, including between LOAD_A and LOAD_B, with no write issued.
REQ-032 SHALL begin the first fetch from PC = 0 in the second rising edge after reset deasserts.

Verification
REQ-033 SHALL check LOAD: InstrData = 16'h21A3 -> LOAD_B cycle with D_Addr = 8'h1A, RF_s = 1, RF_W_en = 1, RF_W_addr = 3, 4 cycles total.
REQ-034 SHALL check ADD: 16'h3452 -> RF_Ra_addr = 4, RF_Rb_addr = 5, RF_W_addr = 2, ALU_s0 = 001, RF_W_en = 1 for exactly one cycle.
REQ-035 SHALL check STORE: 16'h1FF7 -> D_Addr = 8'hFF, RF_Ra_addr = 7, D_Wr = 1 for one cycle, RF_W_en = 0 throughout.
REQ-036 SHALL check HALT: 16'h5000 -> Halted = 1 and State = 9; PC frozen for 20 cycles; no write enables asserted.
REQ-037 SHALL check PC wrap: 128 NOOP words -> PC_Addr sequence 0..127 then back to 0.
REQ-038 SHALL check mid-LOAD reset: reset in LOAD_A -> State = 0, PC = 0 asynchronously, and no RF_W_en pulse.
